// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and default width for the serial adder
package adder_pkg;

    localparam int ADDER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - single-bit combinational full adder
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic sum,
    output logic Cout
);

    assign sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready handshakes
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_cout;

    FA u_fa (
        .A   (a_sr_q[0]),
        .B   (b_sr_q[0]),
        .Cin (carry_q),
        .sum (fa_sum),
        .Cout(fa_cout)
    );

    // Result and final carry come straight from the datapath registers
    assign sum  = sum_sr_q;
    assign cout = carry_q;

    // Next-state, datapath shifting and handshake outputs
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Each new sum bit enters at the MSB so the LSB-first stream
                // ends up in natural order after WIDTH shifts.
                sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d  = fa_cout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // in_valid is ignored here; a new operand set is taken only
                // once the state is back in IDLE.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    logic        w1_in_valid;
    logic        w1_in_ready;
    logic [0:0]  w1_a;
    logic [0:0]  w1_b;
    logic        w1_cin;
    logic        w1_out_valid;
    logic        w1_out_ready;
    logic [0:0]  w1_sum;
    logic        w1_cout;

    int checks;
    int errors;

    serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w1_in_valid),
        .in_ready (w1_in_ready),
        .a        (w1_a),
        .b        (w1_b),
        .cin      (w1_cin),
        .out_valid(w1_out_valid),
        .out_ready(w1_out_ready),
        .sum      (w1_sum),
        .cout     (w1_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, measure latency, check result, then drain it
    task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [15:0] exp_sum, input logic exp_cout);
        int cyc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL %s latency: got %0d want 16", name, cyc);
        end
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            errors++;
            $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum, exp_cout, exp_sum);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: got out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got out_valid=%b sum=%h cout=%b in_ready=%b want 0 0000 0 1",
                     out_valid, sum, cout, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || w1_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b/%b want 1/1", in_ready, w1_in_ready);
        end
    endtask

    task automatic test_zero();
        run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_carry();
        run_op("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("carry_all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    endtask

    task automatic test_hold();
        int cyc;
        int bad;
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        step();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL hold latency: got %0d want 16", cyc);
        end
        // in_valid stays high with different operands during the stall
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || sum !== 16'h5556 || cout !== 1'b0 || in_ready !== 1'b0)
                bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold stable: %0d bad cycles, last out_valid=%b sum=%h cout=%b in_ready=%b want 1 5556 0 0",
                     bad, out_valid, sum, cout, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold release_idle: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort in_run: got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort async_clear: got out_valid=%b sum=%h cout=%b in_ready=%b want 0 0000 0 1",
                     out_valid, sum, cout, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    endtask

    task automatic test_width1();
        int cyc;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            w1_a = 1'(i >> 2);
            w1_b = 1'(i >> 1);
            w1_cin = 1'(i);
            exp = 2'(w1_a) + 2'(w1_b) + 2'(w1_cin);
            w1_in_valid = 1'b1;
            step();
            w1_in_valid = 1'b0;
            cyc = 0;
            while (w1_out_valid !== 1'b1 && cyc < 20) begin
                step();
                cyc++;
            end
            checks++;
            if (cyc !== 1 || {w1_cout, w1_sum} !== exp) begin
                errors++;
                $display("FAIL width1 combo %0d: got latency=%0d cout,sum=%b%b want 1 %b",
                         i, cyc, w1_cout, w1_sum, exp);
            end
            w1_out_ready = 1'b1;
            step();
            w1_out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ca, cb;
        logic        cc;
        logic [16:0] ref_val;
        int          cyc;
        int          bad_lat, bad_res, bad_hs;
        bad_lat = 0; bad_res = 0; bad_hs = 0;
        ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom);
        a = ca; b = cb; cin = cc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ref_val = 17'(ca) + 17'(cb) + 17'(cc);
            step();
            if (in_ready !== 1'b0) bad_hs++;
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 100) begin
                step();
                cyc++;
            end
            if (cyc !== 16) bad_lat++;
            if ({cout, sum} !== ref_val) begin
                bad_res++;
                if (bad_res <= 5)
                    $display("FAIL b2b result %0d: got %h want %h", i, {cout, sum}, ref_val);
            end
            // Next operands presented while still in DONE; they must wait
            ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom);
            a = ca; b = cb; cin = cc;
            step();
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad_hs++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (bad_res !== 0) begin
            errors++;
            $display("FAIL b2b results: got %0d wrong want 0", bad_res);
        end
        checks++;
        if (bad_lat !== 0) begin
            errors++;
            $display("FAIL b2b latency: got %0d wrong want 0", bad_lat);
        end
        checks++;
        if (bad_hs !== 0) begin
            errors++;
            $display("FAIL b2b handshake timing: got %0d wrong want 0", bad_hs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        w1_in_valid = 1'b0; w1_a = '0; w1_b = '0; w1_cin = 1'b0; w1_out_ready = 1'b0;
        test_reset();
        test_zero();
        test_carry();
        test_hold();
        test_abort();
        test_width1();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operands a, b, cin presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum and cout valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 sum  output  WIDTH  A+B+cin, low WIDTH bits.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 Bit-serial addition, LSB first, through one full-adder instance plus a carry register, one bit per clock.
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge loads a, b into shift registers, cin into the carry register, clears the bit counter, goes to RUN.
REQ-016 RUN: each edge, FA(a_sr[0], b_sr[0], carry) sum bit enters sum_sr at its MSB with a right shift; carry <= FA cout; a_sr, b_sr shift right; counter increments.
REQ-017 RUN -> DONE on the edge where the counter equals WIDTH-1; counter width max(1, clog2(WIDTH)).
REQ-018 Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-019 DONE: out_valid=1; sum and cout hold stable until the transfer; out_ready=1 at an edge goes to IDLE.
REQ-020 in_ready=0 in RUN and DONE; in_valid is ignored there and operands are not captured.
REQ-021 Simultaneous out_ready and in_valid in DONE: result transfers, state becomes IDLE, new operands are not accepted that cycle (earliest acceptance one cycle later).
REQ-022 out_valid held indefinitely under out_ready=0; no result is lost or overwritten.
REQ-023 Result equals (A+B+cin) mod 2^(WIDTH+1), split as {cout, sum}, for all inputs.

Reset
REQ-024 rst=1 immediately forces state IDLE, sum=0, cout=0, out_valid=0, counter=0, carry=0, and all shift registers to 0, independent of clk.
REQ-025 rst asserted during RUN or DONE aborts the operation; no partial result is ever presented.
REQ-026 After rst deasserts, in_ready=1 from the first cycle.

Structure
REQ-027 Shared package adder_pkg holds the state typedef (IDLE/RUN/DONE) and the default-width constant ADDER_WIDTH=16.
REQ-028 The one sub-module is FA (ports A, B, Cin, sum, Cout), instantiated once, purely combinational; all sequential logic lives in serial_adder.
REQ-029 cout output is driven from the carry register after the final RUN edge.

Verification
REQ-030 WIDTH=16, a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0; out_valid exactly 16 cycles after acceptance.
REQ-031 WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-032 WIDTH=16, a=0x1234, b=0x4321, cin=1, out_ready=0 for 10 cycles after out_valid -> sum=0x5556, cout=0 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed 5 cycles into RUN -> out_valid, sum, cout go to 0 immediately; next operation 0x00FF+0x0001 -> sum=0x0100, cout=0.
REQ-034 WIDTH=1, all 8 (a,b,cin) combinations -> {cout,sum} matches the full-adder truth table, 1-cycle latency.
REQ-035 Back-to-back: in_valid held high with out_ready=1 -> second operand accepted exactly one cycle after the first result transfers; 1000 random operand sets match the reference sum.
